// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - WIDTH-bit universal shift register with pattern match counter
//
// Purpose: universal shift register (hold / shift right / shift left / parallel
// load) built from preset/clear D flip-flop stages, plus a pattern detector and
// a saturating count of updates that landed on PATTERN.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset (q=0, match_cnt=0)
//   pr_l      in   1      synchronous preset, active low, wins over clr_l
//   clr_l     in   1      synchronous clear, active low
//   mode      in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   sin_r     in   1      serial bit entering the MSB on shift right
//   sin_l     in   1      serial bit entering the LSB on shift left
//   d         in   WIDTH  parallel load data
//   q         out  WIDTH  register contents
//   sout_r    out  1      q[0]
//   sout_l    out  1      q[WIDTH-1]
//   match     out  1      q == PATTERN
//   match_cnt out  CNT_W  saturating count of updates landing on PATTERN

// Single register stage: async reset, then sync preset over sync clear over data.
module usr_pc_dff (
    input  logic clk,
    input  logic rst,
    input  logic pr_l,
    input  logic clr_l,
    input  logic d,
    output logic q
);
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (!pr_l) begin
            r_q <= 1'b1;
        end else if (!clr_l) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;
endmodule

module univ_shift_reg #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pr_l,
    input  logic             clr_l,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_d_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_update;
    logic [CNT_W-1:0] r_cnt;

    // Data presented to the stages when neither preset nor clear is active.
    always_comb begin
        w_d_next = w_q;
        case (mode)
            2'b00:   w_d_next = w_q;
            2'b01:   w_d_next = {sin_r, w_q[WIDTH-1:1]};
            2'b10:   w_d_next = {w_q[WIDTH-2:0], sin_l};
            default: w_d_next = d;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            usr_pc_dff u_stage (
                .clk   (clk),
                .rst   (rst),
                .pr_l  (pr_l),
                .clr_l (clr_l),
                .d     (w_d_next[gi]),
                .q     (w_q[gi])
            );
        end
    endgenerate

    // Value the stages will hold after this edge; the counter needs it to
    // decide whether the update lands on PATTERN.
    always_comb begin
        w_q_next = w_d_next;
        if (!pr_l) begin
            w_q_next = '1;
        end else if (!clr_l) begin
            w_q_next = '0;
        end
    end

    // Hold edges are never updates, even when q already equals PATTERN.
    assign w_update = !pr_l || !clr_l || (mode != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_update && (w_q_next == PATTERN) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign q         = w_q;
    assign sout_r    = w_q[0];
    assign sout_l    = w_q[WIDTH-1];
    assign match     = (w_q == PATTERN);
    assign match_cnt = r_cnt;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;
    localparam int             W    = 4;
    localparam int             CW   = 8;
    localparam logic [W-1:0]   PAT  = 4'b1011;
    localparam int             MASK = (1 << W) - 1;
    localparam int             CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pr_l;
    logic          clr_l;
    logic [1:0]    mode;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  d;
    logic [W-1:0]  q;
    logic          sout_r;
    logic          sout_l;
    logic          match;
    logic [CW-1:0] match_cnt;

    int err_cnt   = 0;
    int check_cnt = 0;
    int m_q       = 0;
    int m_cnt     = 0;

    univ_shift_reg #(.WIDTH(W), .PATTERN(PAT), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pr_l      (pr_l),
        .clr_l     (clr_l),
        .mode      (mode),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .d         (d),
        .q         (q),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .match     (match),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},      32'(q),         32'(m_q));
        check({tag, ".sout_r"}, 32'(sout_r),    32'(m_q % 2));
        check({tag, ".sout_l"}, 32'(sout_l),    32'((m_q >> (W - 1)) % 2));
        check({tag, ".match"},  32'(match),     32'(m_q == int'(PAT)));
        check({tag, ".cnt"},    32'(match_cnt), 32'(m_cnt));
    endtask

    // Reference model: one edge, written from the operation table.
    task automatic model_edge(input bit p, input bit c, input int md, input int sr, input int sl, input int dd);
        int  nq;
        bit  upd;
        upd = !p || !c || (md != 0);
        if (!p)          nq = MASK;
        else if (!c)     nq = 0;
        else if (md == 0) nq = m_q;
        else if (md == 1) nq = (sr << (W - 1)) + (m_q / 2);
        else if (md == 2) nq = ((m_q * 2) + sl) & MASK;
        else             nq = dd;
        if (upd && nq == int'(PAT) && m_cnt < CMAX) m_cnt++;
        m_q = nq;
    endtask

    // Drive inputs between edges, take one rising edge, check 1 time unit later.
    task automatic step(input string tag, input bit p, input bit c, input int md,
                        input int sr, input int sl, input int dd);
        pr_l  = p;
        clr_l = c;
        mode  = 2'(md);
        sin_r = sr[0];
        sin_l = sl[0];
        d     = W'(dd);
        @(posedge clk);
        model_edge(p, c, md, sr, sl, dd);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; pr_l = 1'b1; clr_l = 1'b1; mode = 2'b00;
        sin_r = 1'b0; sin_l = 1'b0; d = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #2 rst = 1'b0;

        // Build match_cnt=3, then load 1010 and reset asynchronously mid-cycle.
        repeat (3) step("pre_load", 1, 1, 3, 0, 0, 4'b1011);
        step("load1010", 1, 1, 3, 0, 0, 4'b1010);
        #2 rst = 1'b1;
        #1;
        m_q = 0; m_cnt = 0;
        check_all("async_rst");
        pr_l = 1'b0; mode = 2'b11; d = 4'b1011;
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_held");
        #2 rst = 1'b0;

        // Load and hold.
        step("load0110", 1, 1, 3, 0, 0, 4'b0110);
        repeat (3) step("hold", 1, 1, 0, 1, 1, 4'b1111);

        // Shift right from zero: 1,1,0,1 -> 1011.
        step("clr_sr", 1, 0, 0, 0, 0, 0);
        step("sr1", 1, 1, 1, 1, 0, 0);
        step("sr2", 1, 1, 1, 1, 0, 0);
        step("sr3", 1, 1, 1, 0, 0, 0);
        step("sr4", 1, 1, 1, 1, 0, 0);
        check("sr_match_lit", 32'(match), 32'd1);
        check("sr_q_lit",     32'(q),     32'b1011);

        // Shift left from zero: 1,0,1,1 -> 1011, then a hold edge.
        step("clr_sl", 1, 0, 2, 0, 0, 0);
        step("sl1", 1, 1, 2, 0, 1, 0);
        step("sl2", 1, 1, 2, 0, 0, 0);
        step("sl3", 1, 1, 2, 0, 1, 0);
        step("sl4", 1, 1, 2, 0, 1, 0);
        step("sl_hold", 1, 1, 0, 0, 0, 0);

        // Preset beats clear and load; then clear alone.
        step("pr_and_clr", 0, 0, 3, 0, 0, 0);
        check("pr_q_lit", 32'(q), 32'hF);
        step("clr_only", 1, 0, 3, 0, 0, 4'b1011);

        // Full replacement by WIDTH right shifts of ones.
        for (int i = 0; i < W; i++) step("sr_fill", 1, 1, 1, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) != 0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, MASK)));
        end

        // Saturation: restart count, then 300 loads of PATTERN.
        #2 rst = 1'b1;
        #1;
        m_q = 0; m_cnt = 0;
        check_all("rst2");
        #2 rst = 1'b0;
        for (int i = 0; i < 300; i++) step("sat", 1, 1, 3, 0, 0, int'(PAT));
        check("sat_lit", 32'(match_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end
endmodule
